// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding,
// board-level window lengths and the down-timer width helper.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

  // 100 ms high / 50 ms gap at 50 MHz
  localparam int BOARD_HIGH_CYCLES = 5_000_000;
  localparam int BOARD_GAP_CYCLES  = 2_500_000;

  // Timer only ever holds window-1, so clog2 of the longer window suffices.
  function automatic int timer_width(input int high_cycles, input int gap_cycles);
    int m;
    m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the HIGH and GAP windows; done flags zero.
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HIGH windows separated by forced gaps,
// queueing events that arrive while busy. Define PULSE_STRETCH_EDGE_EN to
// treat inp as a level and count only its rising edges.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              inp,
  output logic              outp,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf,
  output state_t            state
);

  localparam int TW = timer_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0]     HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic ev;

`ifdef PULSE_STRETCH_EDGE_EN
  logic inp_d;
  logic ev_r;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      inp_d <= 1'b0;
      ev_r  <= 1'b0;
    end else begin
      inp_d <= inp;
      ev_r  <= inp & ~inp_d;
    end
  end

  assign ev = ev_r;
`else
  assign ev = inp;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [PEND_W-1:0] pend_d;
  logic              ovf_d;
  logic              load;
  logic [TW-1:0]     load_val;
  logic              done;
  logic              queue_ev;

  pulse_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // An event on the last GAP cycle is consumed directly by the replay
  // decision instead of being queued.
  assign queue_ev = ev && (state_q != IDLE) && !((state_q == GAP) && done);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_cnt;
    ovf_d    = ovf;
    load     = 1'b0;
    load_val = HIGH_LOAD;
    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = HIGH;
          load    = 1'b1;
        end
      end
      HIGH: begin
        if (done) begin
          state_d  = GAP;
          load     = 1'b1;
          load_val = GAP_LOAD;
        end
      end
      GAP: begin
        if (done) begin
          if ((pend_cnt != '0) || ev) begin
            state_d = HIGH;
            load    = 1'b1;
            if (!ev) pend_d = pend_cnt - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (queue_ev) begin
      if (pend_cnt != PEND_MAX) pend_d = pend_cnt + 1'b1;
      else                      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      outp     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_cnt <= pend_d;
      ovf      <= ovf_d;
      outp     <= (state_d == HIGH);
      busy     <= (state_d != IDLE);
    end
  end

  assign state = state_q;

endmodule
